fake_n64_host: RTL
==================

// Module: fake_n64_host
// PURPOSE
//   Console-side (host) end of the N64 joybus link: counterpart to the fake N64 controller.
//   Serializes one command byte onto the single-wire line, then captures the controller's reply.
//   Decodes reply bits by pulse width, reports status, and detects a missing or stalled reply.
//   Sits between test/top logic (start/cmd) and the shared open-drain data line.
// PARAMETERS
//   CLKS_PER_US   4    sample_clk cycles per microsecond; bit cell = 4*CLKS_PER_US clocks
//   TIMEOUT_CLKS  256  max clocks waiting for any reply falling edge (first bit or between bits)
//   MAX_RETRIES   2    retry count; used only when N64_HOST_AUTO_RETRY_EN is defined
// PORTS
//   sample_clk  in   1   sole clock
//   rst_n       in   1   synchronous reset, active low
//   data_rx     in   1   line level (asynchronous; 2-flop synchronized internally)
//   data_tx     out  1   0 = pull line low, 1 = release
//   start       in   1   1-cycle request; sampled only while busy=0
//   cmd         in   8   command byte, latched when start is accepted
//   busy        out  1   high from accepted start until the done cycle, inclusive
//   done        out  1   1-cycle pulse at end of transaction
//   timeout     out  1   valid with done: reply missing or stalled
//   cmd_err     out  1   valid with done: unsupported cmd, line untouched
//   resp_data   out  32  reply, MSB-first, right-aligned; unused upper bits zero
// BEHAVIOUR
//   Reset (rst_n=0 at edge): data_tx=1, busy=0, done=0, timeout=0, cmd_err=0, resp_data=0, FSM->IDLE.
//   Reset mid-transaction aborts immediately; line released at that same edge.
//   Supported cmds: 0x00/0xFF (info, 24-bit reply), 0x01 (poll, 32-bit reply). Others -> cmd_err.
//   States: IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, DONE.
//   IDLE: start=1 -> latch cmd, busy=1; unsupported -> DONE with cmd_err=1; else TX_BIT.
//   TX_BIT: 8 bits MSB first, 4*CLKS_PER_US clocks each. '0' = low 3*CLKS_PER_US, high CLKS_PER_US;
//     '1' = low CLKS_PER_US, high 3*CLKS_PER_US. After bit 7 -> TX_STOP.
//   TX_STOP: low CLKS_PER_US clocks, then release (data_tx=1) -> RX_WAIT.
//   RX_WAIT: timer clears on entry; synchronized falling edge -> RX_BIT;
//     TIMEOUT_CLKS clocks with no edge -> DONE with timeout=1.
//   RX_BIT: sample synced line 2*CLKS_PER_US clocks after detected fall; high=1, low=0.
//     Shift into resp shadow register; when expected count reached -> RX_STOP, else RX_WAIT.
//   RX_STOP: wait for controller stop bit (fall then rise); rise -> DONE.
//     No fall within TIMEOUT_CLKS, or line low > TIMEOUT_CLKS -> DONE with timeout=1.
//   DONE: one cycle: done=1, resp_data <- shadow (only if timeout=0 and cmd_err=0,
//     else resp_data keeps prior value); busy drops next cycle; FSM -> IDLE.
//   timeout/cmd_err hold until the next accepted start, which clears both.
//   start while busy=1 is ignored (not queued). start in DONE cycle is ignored.
//   data_tx held 1 in every state except TX_BIT/TX_STOP low phases.
//   Host's own edges are not decoded: edge detector armed only on RX_WAIT entry.
//   Falls during RX_BIT sampling window ignored.
//   Counters sized for 4*CLKS_PER_US and TIMEOUT_CLKS; no wrap permitted within a state.
// CONFIGURATION
//   N64_HOST_AUTO_RETRY_EN defined: on timeout, idle line 4*CLKS_PER_US*8 clocks, then
//     retransmit same cmd; up to MAX_RETRIES retries. done/timeout reported only after final
//     attempt; busy stays high across retries; success on any attempt -> timeout=0.
//   Undefined: no retry; first timeout ends transaction. MAX_RETRIES ignored.
// TESTING  (CLKS_PER_US=4, bit cell = 16 clocks)
//   start, cmd=0x01, no reply -> data_tx: 7x(12 low, 4 high), 4 low/12 high, stop 4 low;
//     done + timeout=1 exactly 256 clocks after release; resp_data unchanged.
//   cmd=0x01, model replies 0x8000_0A55 + stop -> done, timeout=0, resp_data=0x8000_0A55.
//   cmd=0x00, model replies 0x050002 -> resp_data=0x0005_0002, done once, busy low next cycle.
//   cmd=0x42 -> done one cycle after start, cmd_err=1, data_tx never leaves 1.
//   rst_n low mid-TX_BIT while data_tx=0 -> data_tx=1, busy=0 at that edge; fresh start works.
//   Model stalls after 10 reply bits -> timeout=1; with AUTO_RETRY_EN and 2nd attempt good ->
//     exactly 2 command frames on line, single done, timeout=0, correct resp_data.

Source files
------------

// File: rtl/fake_n64_host.sv
// Console-side joybus host: shifts out one command byte, then captures the controller reply.
// Define N64_HOST_AUTO_RETRY_EN to retransmit the command after a timeout (up to MAX_RETRIES).
module fake_n64_host #(
    parameter int unsigned CLKS_PER_US  = 4,
    parameter int unsigned TIMEOUT_CLKS = 256,
    parameter int unsigned MAX_RETRIES  = 2
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        data_rx,
    output logic        data_tx,
    input  logic        start,
    input  logic [7:0]  cmd,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        cmd_err,
    output logic [31:0] resp_data
);
    localparam int unsigned CellClks  = 4 * CLKS_PER_US;
    localparam int unsigned RetryClks = 8 * CellClks;
    localparam int unsigned CntMax    = (TIMEOUT_CLKS > RetryClks) ? TIMEOUT_CLKS : RetryClks;
    localparam int unsigned CntW      = $clog2(CntMax + 1);
    localparam int unsigned RetryW    = $clog2(MAX_RETRIES + 2);

`ifdef N64_HOST_AUTO_RETRY_EN
    localparam int unsigned RetryLimit = MAX_RETRIES;
`else
    localparam int unsigned RetryLimit = 0;
`endif

    typedef logic [CntW-1:0]   cnt_t;
    typedef logic [RetryW-1:0] retry_t;
    typedef enum logic [2:0] {
        StIdle, StTxBit, StTxStop, StRxWait, StRxBit, StRxStop, StRetry, StDone
    } state_e;

    localparam cnt_t   UsClks      = cnt_t'(CLKS_PER_US);
    localparam cnt_t   ZeroLow     = cnt_t'(3 * CLKS_PER_US);
    localparam cnt_t   UsLast      = cnt_t'(CLKS_PER_US - 1);
    localparam cnt_t   CellLast    = cnt_t'(CellClks - 1);
    localparam cnt_t   HalfLast    = cnt_t'(2 * CLKS_PER_US - 1);
    localparam cnt_t   TimeoutLast = cnt_t'(TIMEOUT_CLKS - 1);
    localparam cnt_t   RetryLast   = cnt_t'(RetryClks - 1);
    localparam retry_t RetryMax    = retry_t'(RetryLimit);

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] resp_q, resp_d;
    logic        timeout_q, timeout_d;
    logic        cmd_err_q, cmd_err_d;
    logic        stop_low_q, stop_low_d;
    retry_t      retry_q, retry_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    logic       fall, rise, tx_bit, cmd_ok, stall;
    cnt_t       low_len;
    logic [5:0] rx_cnt_inc, rx_last;

    assign fall       = rx_prev_q & ~rx_sync_q;
    assign rise       = ~rx_prev_q & rx_sync_q;
    assign tx_bit     = cmd_q[3'd7 - bit_idx_q];
    assign low_len    = tx_bit ? UsClks : ZeroLow;
    assign cmd_ok     = (cmd == 8'h00) || (cmd == 8'h01) || (cmd == 8'hFF);
    assign rx_last    = (cmd_q == 8'h01) ? 6'd32 : 6'd24;
    assign rx_cnt_inc = rx_cnt_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + cnt_t'(1);
        bit_idx_d  = bit_idx_q;
        rx_cnt_d   = rx_cnt_q;
        cmd_d      = cmd_q;
        shadow_d   = shadow_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        cmd_err_d  = cmd_err_q;
        stop_low_d = stop_low_q;
        retry_d    = retry_q;
        data_tx    = 1'b1;
        stall      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    cmd_d     = cmd;
                    timeout_d = 1'b0;
                    cmd_err_d = 1'b0;
                    retry_d   = '0;
                    bit_idx_d = '0;
                    rx_cnt_d  = '0;
                    shadow_d  = '0;
                    if (cmd_ok) begin
                        state_d = StTxBit;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StTxBit: begin
                data_tx = (cnt_q >= low_len);
                if (cnt_q == CellLast) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StTxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StTxStop: begin
                data_tx = 1'b0;
                if (cnt_q == UsLast) begin
                    cnt_d   = '0;
                    state_d = StRxWait;
                end
            end
            StRxWait: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = StRxBit;
                end else if (cnt_q == TimeoutLast) begin
                    stall = 1'b1;
                end
            end
            StRxBit: begin
                // Mid-cell sample: '1' has already risen, '0' is still held low.
                if (cnt_q == HalfLast) begin
                    cnt_d    = '0;
                    shadow_d = {shadow_q[30:0], rx_sync_q};
                    rx_cnt_d = rx_cnt_inc;
                    if (rx_cnt_inc == rx_last) begin
                        stop_low_d = 1'b0;
                        state_d    = StRxStop;
                    end else begin
                        state_d = StRxWait;
                    end
                end
            end
            StRxStop: begin
                if (!stop_low_q) begin
                    if (fall) begin
                        cnt_d      = '0;
                        stop_low_d = 1'b1;
                    end else if (cnt_q == TimeoutLast) begin
                        stall = 1'b1;
                    end
                end else if (rise) begin
                    cnt_d   = '0;
                    resp_d  = shadow_q;
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    stall = 1'b1;
                end
            end
            StRetry: begin
                if (cnt_q == RetryLast) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    rx_cnt_d  = '0;
                    shadow_d  = '0;
                    retry_d   = retry_q + retry_t'(1);
                    state_d   = StTxBit;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (stall) begin
            cnt_d = '0;
            if (retry_q != RetryMax) begin
                state_d = StRetry;
            end else begin
                timeout_d = 1'b1;
                state_d   = StDone;
            end
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            rx_cnt_q   <= '0;
            cmd_q      <= '0;
            shadow_q   <= '0;
            resp_q     <= '0;
            timeout_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            stop_low_q <= 1'b0;
            retry_q    <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            rx_cnt_q   <= rx_cnt_d;
            cmd_q      <= cmd_d;
            shadow_q   <= shadow_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            cmd_err_q  <= cmd_err_d;
            stop_low_q <= stop_low_d;
            retry_q    <= retry_d;
            rx_meta_q  <= data_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign timeout   = timeout_q;
    assign cmd_err   = cmd_err_q;
    assign resp_data = resp_q;

endmodule
